// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned GAP_W          = 16;
   localparam int unsigned GAP_CYCLES_DEF = 16;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WAIT = 3'd2,
      SEND = 3'd3,
      GAP  = 3'd4
   } txc_state_t;

endpackage

// File: rtl/uart_tx_fifo_ctrl.sv
// Transmit scheduler: issues single FIFO read strobes and hands bytes to the UART framer.
// Build option TXC_GAP_EN inserts GAP_CYCLES idle clocks after each accepted byte.
module uart_tx_fifo_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable_i,
   input  logic                 abort_i,
   input  logic [BYTE_W-1:0]    fifo_data_i,
   input  logic                 fifo_empty_i,
   output logic                 fifo_n_re_o,
   output logic [BYTE_W-1:0]    tx_data_o,
   output logic                 tx_valid_o,
   input  logic                 tx_ready_i,
   output logic                 busy_o,
   output logic [CNT_WIDTH-1:0] sent_cnt_o
);

   if (GAP_CYCLES < 1 || GAP_CYCLES > (2 ** GAP_W) - 1) begin : g_gap_range
      $error("uart_tx_fifo_ctrl: GAP_CYCLES must be in 1..65535");
   end

   txc_state_t       state;
   logic             rd_hold;
   logic             handshake;
   logic             start_ok;
`ifdef TXC_GAP_EN
   logic [GAP_W-1:0] gap_cnt;
`endif

   assign handshake = tx_valid_o && tx_ready_i;

   // rd_hold masks the IDLE cycle right after an aborted RD, when the empty flag is still stale
   assign start_ok  = enable_i && !fifo_empty_i && !abort_i && !rd_hold;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         rd_hold     <= 1'b0;
         fifo_n_re_o <= 1'b1;
         tx_data_o   <= '0;
         tx_valid_o  <= 1'b0;
         busy_o      <= 1'b0;
         sent_cnt_o  <= '0;
`ifdef TXC_GAP_EN
         gap_cnt     <= '0;
`endif
      end else begin
         rd_hold     <= 1'b0;
         fifo_n_re_o <= 1'b1;

         // An accepted byte always counts, even if abort_i arrives in the same cycle
         if (handshake) begin
            tx_valid_o <= 1'b0;
            sent_cnt_o <= sent_cnt_o + CNT_WIDTH'(1);
         end

         case (state)
            IDLE: begin
               if (start_ok) begin
                  state       <= RD;
                  fifo_n_re_o <= 1'b0;
                  busy_o      <= 1'b1;
               end
            end
            RD: begin
               rd_hold <= 1'b1;
               if (abort_i) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (abort_i) begin
                  state      <= IDLE;
                  tx_valid_o <= 1'b0;
                  busy_o     <= 1'b0;
               end else begin
                  tx_data_o  <= fifo_data_i;
                  tx_valid_o <= 1'b1;
                  state      <= SEND;
               end
            end
            SEND: begin
               if (abort_i) begin
                  state      <= IDLE;
                  tx_valid_o <= 1'b0;
                  busy_o     <= 1'b0;
               end else if (handshake) begin
`ifdef TXC_GAP_EN
                  state   <= GAP;
                  gap_cnt <= GAP_W'(GAP_CYCLES - 1);
`else
                  state   <= IDLE;
                  busy_o  <= 1'b0;
`endif
               end
            end
`ifdef TXC_GAP_EN
            GAP: begin
               if (abort_i || gap_cnt == '0) begin
                  state   <= IDLE;
                  busy_o  <= 1'b0;
                  gap_cnt <= '0;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
`endif
            default: begin
               state      <= IDLE;
               tx_valid_o <= 1'b0;
               busy_o     <= 1'b0;
            end
         endcase
      end
   end

endmodule
